multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Control unit that drives the datapath control inputs (pcsrc, alusrc, aluop, mrw, wb, regrw, immgen_ctrl) from the current instruction and the ALU status flags.
- Multi-cycle FSM for an RV32I subset, with a ready handshake to the shared instruction/data memory.
- Sits beside the datapath in Top and replaces bench-driven control values.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instr  input  32  instruction register output; the datapath holds it stable from DECODE until the end of the instruction
status  input  5  ALU flags: [0] Z, [1] N, [2] C (1 = no borrow on SUB), [3] V, [4] reserved/ignored
mem_ready  input  1  memory completes the current request this cycle
mem_req  output  1  memory request valid
mrw  output  1  1 = read, 0 = write; 0 only in MEM state for stores
pcsrc  output  1  0 = PC+4, 1 = branch target (PC+imm)
pc_we  output  1  PC write enable
ir_we  output  1  instruction register write enable
alusrc  output  1  1 = ALU B from rs2, 0 = from immediate
aluop  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASSB
wb  output  1  writeback select: 0 = ALU result, 1 = memory data
regrw  output  1  register file write enable
immgen_ctrl  output  2  00 I-type, 01 S-type, 10 B-type, 11 U-type
illegal  output  1  sticky flag: unsupported opcode seen
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
retired  output  CNT_W  count of completed instructions

Behaviour:
- Output reset values, applied during the reset cycle and in the first FETCH after it: state=FETCH, retired=0, illegal=0, regrw=0, pc_we=0, ir_we=0, mrw=1, pcsrc=0, alusrc=1, aluop=0000, wb=0, immgen_ctrl=00. mem_req=0 while reset is high.
- Outputs are combinational from the state register and instr. Unlisted outputs hold their reset value in every state.
- Supported opcodes: R 0110011, I-ALU 0010011, LW 0000011 (f3=010), SW 0100011 (f3=010), BRANCH 1100011, LUI 0110111.
- ALU op mapping:
  - R-type: f3 000 → ADD, or SUB when f7[5]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when f7[5]=1; 110 OR; 111 AND.
  - I-ALU: same as R-type, except f3=000 is always ADD and f7[5] only selects SRA for f3=101.
- FETCH: mem_req=1, mrw=1.
  - mem_ready=1 → ir_we=1, pc_we=1, pcsrc=0; next DECODE.
  - Otherwise stay in FETCH (unbounded wait).
- DECODE: immgen_ctrl set from the opcode.
  - Supported opcode → EXEC.
  - Unsupported opcode, or LW/SW with f3≠010, or BRANCH with f3 in {010, 011} → TRAP.
- EXEC:
  - R-type: alusrc=1, mapped op, then WB.
  - I-ALU: alusrc=0, immgen=00, mapped op, then WB.
  - LUI: alusrc=0, immgen=11, aluop=PASSB, then WB.
  - LW: immgen=00, alusrc=0, ADD, then MEM. SW: same but immgen=01.
  - BRANCH: alusrc=1, SUB, immgen=10. Condition by f3: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C. Taken → pc_we=1, pcsrc=1. Not taken → pc_we=0. Next FETCH; retired increments.
- MEM: mem_req=1; aluop/alusrc/immgen held as in EXEC.
  - Load: mrw=1. mem_ready=1 → WB.
  - Store: mrw=0. mem_ready=1 → FETCH, retired increments.
  - Otherwise stay in MEM.
- WB: regrw=1 for exactly one cycle; wb=1 for LW, 0 otherwise. Next FETCH, retired increments.
- TRAP: illegal=1, all enables 0, mem_req=0. Stays in TRAP until reset.
- retired wraps modulo 2^CNT_W and never increments in TRAP.
- Reset high in any state, including mid-handshake: next state FETCH, counters and flags cleared. Any mem_ready in that cycle is ignored.
- mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset, then instr=0x002081B3 (add x3,x1,x2), mem_ready=1 in FETCH → states 0,1,2,4,0. EXEC: aluop=0000, alusrc=1. WB: regrw=1, wb=0. retired=1.
- instr=0x0000A183 (lw x3,0(x1)), mem_ready low 3 cycles in MEM → mem_req=1, mrw=1 held for 3 cycles. Then WB with wb=1, regrw=1. Total 8 cycles from FETCH to next FETCH.
- instr=0x0030A223 (sw) → MEM with mrw=0, immgen=01. Never regrw=1. Back to FETCH after mem_ready.
- instr=0x00208463 (beq): status=00001 → pc_we=1, pcsrc=1. status=00000 → pc_we=0. Both cases return to FETCH after EXEC.
- instr=0xFFFFFFFF → TRAP from DECODE, illegal=1, mem_req=0 for 10 cycles. reset → state=0, illegal=0, retired=0.
- Reset asserted in MEM while mem_ready=1 → next cycle state=FETCH, regrw=0, retired=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the multi-cycle control unit and the shared
// instruction/data memory.
//
// Signals:
//   mem_req   - control -> memory: a request is valid this cycle
//   mrw       - control -> memory: 1 = read, 0 = write
//   mem_ready - memory -> control: the current request completes this cycle
//
// Modports:
//   master - the control unit (drives mem_req/mrw, samples mem_ready)
//   slave  - the memory side (samples mem_req/mrw, drives mem_ready)
interface multicycle_control_if;
  logic mem_req;
  logic mrw;
  logic mem_ready;

  modport master (
    output mem_req,
    output mrw,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mrw,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for an RV32I subset (R, I-ALU, LW, SW, BRANCH, LUI).
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and drives the datapath
// control inputs from the state register, the held instruction and ALU flags.
// Unsupported encodings park the unit in TRAP until reset.
//
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high reset
//   instr       - instruction register contents, stable from DECODE onward
//   status      - ALU flags: [0] Z, [1] N, [2] C (no borrow), [3] V, [4] ignored
//   mem         - memory handshake (mem_req, mrw, mem_ready), master side
//   pcsrc       - 0 = PC+4, 1 = branch target
//   pc_we       - PC write enable
//   ir_we       - instruction register write enable
//   alusrc      - 1 = ALU B from rs2, 0 = from immediate
//   aluop       - ALU operation select
//   wb          - writeback select: 0 = ALU result, 1 = memory data
//   regrw       - register file write enable
//   immgen_ctrl - 00 I, 01 S, 10 B, 11 U immediate format
//   illegal     - sticky unsupported-instruction flag
//   state       - FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
//   retired     - completed-instruction counter, wraps modulo 2^CNT_W
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic [4:0]           status,
  multicycle_control_if.master mem,
  output logic                 pcsrc,
  output logic                 pc_we,
  output logic                 ir_we,
  output logic                 alusrc,
  output logic [3:0]           aluop,
  output logic                 wb,
  output logic                 regrw,
  output logic [1:0]           immgen_ctrl,
  output logic                 illegal,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluAnd   = 4'b0010;
  localparam logic [3:0] AluOr    = 4'b0011;
  localparam logic [3:0] AluXor   = 4'b0100;
  localparam logic [3:0] AluSll   = 4'b0101;
  localparam logic [3:0] AluSrl   = 4'b0110;
  localparam logic [3:0] AluSra   = 4'b0111;
  localparam logic [3:0] AluSlt   = 4'b1000;
  localparam logic [3:0] AluSltu  = 4'b1001;
  localparam logic [3:0] AluPassB = 4'b1010;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmU = 2'b11;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];

  // Register numbers, immediates and the reserved flag are datapath concerns.
  logic unused_bits;
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], status[4]};

  logic is_r, is_imm, is_load, is_store, is_branch, is_lui;
  logic instr_legal;

  assign is_r      = (opcode == OpR);
  assign is_imm    = (opcode == OpImm);
  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBranch);
  assign is_lui    = (opcode == OpLui);

  // Only word accesses are supported; branch funct3 010/011 are unassigned.
  assign instr_legal = is_r | is_imm | is_lui |
                       ((is_load | is_store) & (funct3 == 3'b010)) |
                       (is_branch & (funct3[2:1] != 2'b01));

  // ALU op from funct3; alt selects SUB (funct3 000) or SRA (funct3 101).
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic [3:0] r_aluop, i_aluop;

  assign r_aluop = alu_map(funct3, funct7_5);
  // For I-ALU, bit 30 is immediate data except on shift-right.
  assign i_aluop = alu_map(funct3, funct7_5 & (funct3 == 3'b101));

  // Branch condition from the SUB flags of rs1 - rs2.
  logic flag_z, flag_n, flag_c, flag_v;
  logic branch_taken;

  assign flag_z = status[0];
  assign flag_n = status[1];
  assign flag_c = status[2];
  assign flag_v = status[3];

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = flag_z;
      3'b001:  branch_taken = ~flag_z;
      3'b100:  branch_taken = flag_n ^ flag_v;
      3'b101:  branch_taken = ~(flag_n ^ flag_v);
      3'b110:  branch_taken = ~flag_c;
      3'b111:  branch_taken = flag_c;
      default: branch_taken = 1'b0;
    endcase
  end

  logic [1:0] imm_sel;

  always_comb begin
    imm_sel = ImmI;
    case (opcode)
      OpStore:  imm_sel = ImmS;
      OpBranch: imm_sel = ImmB;
      OpLui:    imm_sel = ImmU;
      default:  imm_sel = ImmI;
    endcase
  end

  // Next state and outputs
  always_comb begin
    state_d     = state_q;
    retired_d   = retired_q;
    illegal_d   = illegal_q;

    mem.mem_req = 1'b0;
    mem.mrw     = 1'b1;
    pcsrc       = 1'b0;
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    alusrc      = 1'b1;
    aluop       = AluAdd;
    wb          = 1'b0;
    regrw       = 1'b0;
    immgen_ctrl = ImmI;

    // While reset is high every output stays at its idle value.
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = StDecode;
          end
        end

        StDecode: begin
          immgen_ctrl = imm_sel;
          if (instr_legal) begin
            state_d = StExec;
          end else begin
            state_d   = StTrap;
            illegal_d = 1'b1;
          end
        end

        StExec: begin
          if (is_r) begin
            alusrc  = 1'b1;
            aluop   = r_aluop;
            state_d = StWb;
          end else if (is_imm) begin
            alusrc  = 1'b0;
            aluop   = i_aluop;
            state_d = StWb;
          end else if (is_lui) begin
            alusrc      = 1'b0;
            immgen_ctrl = ImmU;
            aluop       = AluPassB;
            state_d     = StWb;
          end else if (is_load || is_store) begin
            alusrc      = 1'b0;
            immgen_ctrl = is_store ? ImmS : ImmI;
            aluop       = AluAdd;
            state_d     = StMem;
          end else if (is_branch) begin
            alusrc      = 1'b1;
            aluop       = AluSub;
            immgen_ctrl = ImmB;
            pc_we       = branch_taken;
            pcsrc       = branch_taken;
            state_d     = StFetch;
            retired_d   = retired_q + CNT_W'(1);
          end else begin
            // Unreachable while instr is held; fail safe rather than guess.
            state_d   = StTrap;
            illegal_d = 1'b1;
          end
        end

        StMem: begin
          mem.mem_req = 1'b1;
          mem.mrw     = ~is_store;
          alusrc      = 1'b0;
          aluop       = AluAdd;
          immgen_ctrl = is_store ? ImmS : ImmI;
          if (mem.mem_ready) begin
            if (is_store) begin
              state_d   = StFetch;
              retired_d = retired_q + CNT_W'(1);
            end else begin
              state_d = StWb;
            end
          end
        end

        StWb: begin
          regrw     = 1'b1;
          wb        = is_load;
          state_d   = StFetch;
          retired_d = retired_q + CNT_W'(1);
        end

        StTrap: begin
          state_d = StTrap;
        end

        default: begin
          state_d = StFetch;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = reset ? StFetch : state_q;
  assign retired = reset ? '0 : retired_q;
  assign illegal = reset ? 1'b0 : illegal_q;

endmodule
